// File: rtl/rr_mux_stream_pkg.sv
// ============================================================================
// Module : rr_mux_pkg
// Brief  : Shared constants, pick-result type and the wrap-around channel
//          search used by the rr_mux_stream arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rr_mux_pkg;

    localparam int RR_DEF_N_CH = 8;
    localparam int RR_DEF_W    = 8;
    localparam int RR_MAX_CH   = 16;
    localparam int RR_IDX_W    = 4;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] index;
    } rr_pick_t;

    // First set bit of valid, searching ptr, ptr+1, ..., n_ch-1, 0, ..., ptr-1.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_CH-1:0] valid,
        input logic [RR_IDX_W-1:0]  ptr,
        input int                   n_ch
    );
        rr_pick_t r;
        int       idx;
        r = '0;
        for (int k = 0; k < RR_MAX_CH; k++) begin
            if (k < n_ch) begin
                idx = int'(ptr) + k;
                if (idx >= n_ch) begin
                    idx = idx - n_ch;
                end
                if (!r.found && valid[idx[RR_IDX_W-1:0]]) begin
                    r.found = 1'b1;
                    r.index = idx[RR_IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_mux_stream_if.sv
// ============================================================================
// Module : rr_mux_stream_if
// Brief  : Producer-side and consumer-side handshake bundle of rr_mux_stream.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rr_mux_stream_if import rr_mux_pkg::*; #(
    parameter int N_CH = RR_DEF_N_CH,
    parameter int W    = RR_DEF_W
);
    localparam int SEL_W = $clog2(N_CH);

    logic [N_CH*W-1:0] in_data;
    logic [N_CH-1:0]   in_valid;
    logic [N_CH-1:0]   in_ready;
    logic [W-1:0]      out_data;
    logic [SEL_W-1:0]  out_sel;
    logic              out_valid;
    logic              out_ready;

    // Environment side: drives producers and the consumer ready.
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    // Multiplexer side.
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

endinterface

`default_nettype wire

// File: rtl/rr_mux_stream_arb.sv
// ============================================================================
// Module : rr_arb
// Brief  : Combinational channel arbiter: valid + ptr -> one-hot grant,
//          index, found. Fixed lowest-index priority when
//          RR_MUX_FIXED_PRIO_EN is defined, round-robin otherwise.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arb import rr_mux_pkg::*; #(
    parameter int N_CH = RR_DEF_N_CH,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  wire logic [N_CH-1:0]  valid,
    input  wire logic [SEL_W-1:0] ptr,
    output logic      [N_CH-1:0]  grant,
    output logic      [SEL_W-1:0] index,
    output logic                  found
);

    logic [RR_MAX_CH-1:0] w_valid_ext;
    logic [RR_IDX_W-1:0]  w_ptr_ext;
    rr_pick_t             w_pick;

`ifdef RR_MUX_FIXED_PRIO_EN
    // Searching from zero makes the lowest valid index win every time.
    wire w_unused_ptr = ^ptr;
    always_comb begin
        w_ptr_ext = '0;
    end
`else
    always_comb begin
        w_ptr_ext             = '0;
        w_ptr_ext[SEL_W-1:0]  = ptr;
    end
`endif

    always_comb begin
        w_valid_ext            = '0;
        w_valid_ext[N_CH-1:0]  = valid;
        w_pick                 = rr_pick(w_valid_ext, w_ptr_ext, N_CH);
    end

    wire w_unused_idx = ^w_pick.index;

    assign found = w_pick.found;
    assign index = w_pick.index[SEL_W-1:0];
    assign grant = w_pick.found ? (N_CH'(1) << w_pick.index) : '0;

endmodule

`default_nettype wire

// File: rtl/rr_mux_stream.sv
// ============================================================================
// Module : rr_mux_stream
// Brief  : N-channel W-bit streaming mux with round-robin selection and a
//          registered output stage. Define RR_MUX_FIXED_PRIO_EN for fixed
//          lowest-index priority (pointer tied to zero).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_mux_stream import rr_mux_pkg::*; #(
    parameter int N_CH = RR_DEF_N_CH,
    parameter int W    = RR_DEF_W
) (
    input  wire logic       clk,
    input  wire logic       rst,
    rr_mux_stream_if.slave  bus
);

    localparam int               SEL_W  = $clog2(N_CH);
    localparam logic [SEL_W-1:0] c_last = SEL_W'(N_CH - 1);

    logic             w_load;
    logic             w_found;
    logic             w_take;
    logic [N_CH-1:0]  w_grant;
    logic [SEL_W-1:0] w_idx;
    logic [SEL_W-1:0] w_ptr;
    logic [W-1:0]     w_sel_data;

    logic [W-1:0]     r_out_data;
    logic [SEL_W-1:0] r_out_sel;
    logic             r_out_valid;

    // The output slot is free when empty or being drained this cycle.
    assign w_load = !r_out_valid || bus.out_ready;
    assign w_take = w_load && w_found;

    rr_arb #(.N_CH(N_CH)) u_arb (
        .valid (bus.in_valid),
        .ptr   (w_ptr),
        .grant (w_grant),
        .index (w_idx),
        .found (w_found)
    );

    assign w_sel_data   = bus.in_data[int'(w_idx)*W +: W];
    assign bus.in_ready = (w_load && !rst) ? w_grant : '0;

`ifdef RR_MUX_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [SEL_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_take) begin
            r_ptr <= (w_idx == c_last) ? '0 : w_idx + 1'b1;
        end
    end

    assign w_ptr = r_ptr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_load) begin
            r_out_valid <= w_found;
            if (w_found) begin
                r_out_data <= w_sel_data;
                r_out_sel  <= w_idx;
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;
    assign bus.out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_stream.sv
// ============================================================================
// Module : tb_rr_mux_stream
// Brief  : Directed self-checking bench for rr_mux_stream (8- and 5-channel).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rr_mux_stream;

`ifdef RR_MUX_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_mux_stream_if #(.N_CH(8), .W(8)) bus8();
    rr_mux_stream_if #(.N_CH(5), .W(8)) bus5();

    rr_mux_stream #(.N_CH(8), .W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    rr_mux_stream #(.N_CH(5), .W(8)) u_dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Channel i of the 8-channel instance carries 8'h10+i.
    task automatic chk8(input string tag, input int sel);
        chk({tag, ".valid"}, 32'(bus8.out_valid), 32'd1);
        chk({tag, ".sel"},   32'(bus8.out_sel),   32'(sel));
        chk({tag, ".data"},  32'(bus8.out_data),  32'(8'h10 + sel));
    endtask

    task automatic chk5(input string tag, input int sel);
        chk({tag, ".valid"}, 32'(bus5.out_valid), 32'd1);
        chk({tag, ".sel"},   32'(bus5.out_sel),   32'(sel));
        chk({tag, ".data"},  32'(bus5.out_data),  32'(8'h50 + sel));
    endtask

    initial begin
        bus8.in_valid  = 8'hFF;
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) bus8.in_data[i*8 +: 8] = 8'(8'h10 + i);
        bus5.in_valid  = 5'b0;
        bus5.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) bus5.in_data[i*8 +: 8] = 8'(8'h50 + i);

        // Reset held with every producer valid.
        rst = 1'b1;
        tick();
        tick();
        chk("rst.out_valid", 32'(bus8.out_valid), 32'd0);
        chk("rst.out_data",  32'(bus8.out_data),  32'd0);
        chk("rst.out_sel",   32'(bus8.out_sel),   32'd0);
        chk("rst.in_ready",  32'(bus8.in_ready),  32'd0);
        chk("rst5.out_valid", 32'(bus5.out_valid), 32'd0);

        // Single channel 3 word.
        rst = 1'b0;
        bus8.in_valid = 8'h08;
        bus8.in_data[31:24] = 8'hA5;
        #1;
        chk("ch3.in_ready", 32'(bus8.in_ready), 32'h08);
        tick();
        bus8.in_valid = 8'h00;
        chk("ch3.out_valid", 32'(bus8.out_valid), 32'd1);
        chk("ch3.out_data",  32'(bus8.out_data),  32'hA5);
        chk("ch3.out_sel",   32'(bus8.out_sel),   32'd3);
        tick();
        chk("idle.out_valid", 32'(bus8.out_valid), 32'd0);
        chk("idle.out_data",  32'(bus8.out_data),  32'hA5);
        chk("idle.out_sel",   32'(bus8.out_sel),   32'd3);

        // Fresh pointer, then all channels valid back to back.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus8.in_data[31:24] = 8'h13;
        bus8.in_valid = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk8($sformatf("rr%0d", k), FIXED ? 0 : k % 8);
        end

        // Backpressure: everything frozen.
        bus8.out_ready = 1'b0;
        #1;
        chk("bp.in_ready", 32'(bus8.in_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk8($sformatf("bp%0d", k), FIXED ? 0 : 1);
            chk($sformatf("bp%0d.in_ready", k), 32'(bus8.in_ready), 32'd0);
        end
        bus8.out_ready = 1'b1;
        #1;
        chk("rel.in_ready", 32'(bus8.in_ready), FIXED ? 32'h01 : 32'h04);
        tick();
        chk8("rel", FIXED ? 0 : 2);

        // Wrap from channel 7 back to channel 0.
        bus8.in_valid = 8'h40;
        tick();
        chk8("wrap.a", 6);
        bus8.in_valid = 8'h81;
        tick();
        chk8("wrap.b", FIXED ? 0 : 7);
        tick();
        chk8("wrap.c", 0);
        tick();
        chk8("wrap.d", FIXED ? 0 : 7);

        // Non-power-of-two wrap on the 5-channel instance.
        bus8.in_valid = 8'h00;
        bus5.in_valid = 5'b01000;
        tick();
        chk5("n5.a", 3);
        bus5.in_valid = 5'b10001;
        tick();
        chk5("n5.b", FIXED ? 0 : 4);
        tick();
        chk5("n5.c", 0);
        bus5.in_valid = 5'b00000;

        // Channels 1 and 6 competing, then channel 1 drops out.
        bus8.in_valid = 8'h42;
        tick();
        chk8("pair.a", 1);
        tick();
        chk8("pair.b", FIXED ? 1 : 6);
        tick();
        chk8("pair.c", 1);
        bus8.in_valid = 8'h40;
        tick();
        chk8("pair.d", 6);

        // Reset while a word is stalled at the output.
        bus8.out_ready = 1'b0;
        bus8.in_valid  = 8'hFF;
        tick();
        chk8("stall", 6);
        rst = 1'b1;
        tick();
        chk("mrst.out_valid", 32'(bus8.out_valid), 32'd0);
        chk("mrst.out_sel",   32'(bus8.out_sel),   32'd0);
        chk("mrst.out_data",  32'(bus8.out_data),  32'd0);
        chk("mrst.in_ready",  32'(bus8.in_ready),  32'd0);
        rst = 1'b0;
        bus8.out_ready = 1'b1;
        #1;
        chk("mrst.grant", 32'(bus8.in_ready), 32'h01);
        tick();
        chk8("mrst.first", 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
